// File: rtl/pmem_pkg.sv
// pmem_pkg: shared types and helpers for the program-memory fetch arbiter
package pmem_pkg;
  typedef enum logic [1:0] {IDLE, REQ, RELAY} chan_state_t;
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/pmem_rr_picker.sv
// pmem_rr_picker: picks the first set request scanning from ptr upward with wrap
module pmem_rr_picker import pmem_pkg::*; #(
  parameter int N  = 2,
  parameter int PW = clog2_min1(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic          grant_valid_o,
  output logic [PW-1:0] grant_idx_o
);
  logic [PW-1:0] j;
  // Scanning downward lets the closest-to-ptr hit overwrite farther ones
  always_comb begin
    grant_valid_o = 1'b0;
    grant_idx_o = '0;
    j = '0;
    for (int i = N - 1; i >= 0; i--) begin
      j = (int'(ptr_i) + i >= N) ? PW'(int'(ptr_i) + i - N) : PW'(int'(ptr_i) + i);
      if (req_i[j]) begin
        grant_valid_o = 1'b1;
        grant_idx_o = j;
      end
    end
  end
endmodule

// File: rtl/pmem_fetch_arbiter.sv
// pmem_fetch_arbiter: shares program-memory cache channels among core fetchers,
// granting one pending fetch per cycle round-robin onto the lowest idle channel.
module pmem_fetch_arbiter import pmem_pkg::*; #(
  parameter int ADDR_BITS     = 8,
  parameter int DATA_BITS     = 16,
  parameter int NUM_CONSUMERS = 2,
  parameter int NUM_CHANNELS  = 1
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [NUM_CONSUMERS-1:0]          consumer_read_valid_i,
  input  logic [ADDR_BITS*NUM_CONSUMERS-1:0] consumer_read_address_i,
  output logic [NUM_CONSUMERS-1:0]          consumer_read_ready_o,
  output logic [DATA_BITS*NUM_CONSUMERS-1:0] consumer_read_data_o,
  output logic [NUM_CHANNELS-1:0]           cache_read_valid_o,
  output logic [ADDR_BITS*NUM_CHANNELS-1:0] cache_read_address_o,
  input  logic [NUM_CHANNELS-1:0]           cache_read_ready_i,
  input  logic [DATA_BITS*NUM_CHANNELS-1:0] cache_read_data_i
);
  localparam int PW = clog2_min1(NUM_CONSUMERS);
  localparam int CW = clog2_min1(NUM_CHANNELS);

  chan_state_t                       state_q [NUM_CHANNELS];
  logic [PW-1:0]                     owner_q [NUM_CHANNELS];
  logic [NUM_CONSUMERS-1:0]          busy_q;
  logic [PW-1:0]                     rr_ptr_q;
  logic [NUM_CONSUMERS-1:0]          ready_q;
  logic [DATA_BITS*NUM_CONSUMERS-1:0] data_q;
  logic [NUM_CHANNELS-1:0]           cvalid_q;
  logic [ADDR_BITS*NUM_CHANNELS-1:0] caddr_q;

  logic [NUM_CONSUMERS-1:0] pending;
  logic                     win_valid;
  logic [PW-1:0]            win;
  logic                     chan_free;
  logic [CW-1:0]            chan_idx;
  logic                     grant;

  assign pending = consumer_read_valid_i & ~busy_q;

  pmem_rr_picker #(.N(NUM_CONSUMERS), .PW(PW)) u_picker (
    .req_i         (pending),
    .ptr_i         (rr_ptr_q),
    .grant_valid_o (win_valid),
    .grant_idx_o   (win)
  );

  always_comb begin
    chan_free = 1'b0;
    chan_idx = '0;
    for (int k = NUM_CHANNELS - 1; k >= 0; k--) begin
      if (state_q[k] == IDLE) begin
        chan_free = 1'b1;
        chan_idx = CW'(k);
      end
    end
  end

  assign grant = win_valid & chan_free;

  // A consumer is owned by at most one channel, so per-consumer writes never collide
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_CHANNELS; k++) begin
        state_q[k] <= IDLE;
        owner_q[k] <= '0;
      end
      busy_q <= '0;
      rr_ptr_q <= '0;
      ready_q <= '0;
      data_q <= '0;
      cvalid_q <= '0;
      caddr_q <= '0;
    end else begin
      for (int k = 0; k < NUM_CHANNELS; k++) begin
        if (state_q[k] == IDLE && grant && chan_idx == CW'(k)) begin
          owner_q[k] <= win;
          busy_q[win] <= 1'b1;
          caddr_q[k*ADDR_BITS +: ADDR_BITS] <= consumer_read_address_i[int'(win)*ADDR_BITS +: ADDR_BITS];
          cvalid_q[k] <= 1'b1;
          state_q[k] <= REQ;
        end else if (state_q[k] == REQ && cache_read_ready_i[k]) begin
          cvalid_q[k] <= 1'b0;
          ready_q[owner_q[k]] <= 1'b1;
          data_q[int'(owner_q[k])*DATA_BITS +: DATA_BITS] <= cache_read_data_i[k*DATA_BITS +: DATA_BITS];
          state_q[k] <= RELAY;
        end else if (state_q[k] == RELAY && !consumer_read_valid_i[owner_q[k]] && !cache_read_ready_i[k]) begin
          ready_q[owner_q[k]] <= 1'b0;
          data_q[int'(owner_q[k])*DATA_BITS +: DATA_BITS] <= '0;
          busy_q[owner_q[k]] <= 1'b0;
          state_q[k] <= IDLE;
        end
      end
      if (grant)
        rr_ptr_q <= (win == PW'(NUM_CONSUMERS - 1)) ? '0 : win + 1'b1;
    end
  end

  assign consumer_read_ready_o = ready_q;
  assign consumer_read_data_o  = data_q;
  assign cache_read_valid_o    = cvalid_q;
  assign cache_read_address_o  = caddr_q;
endmodule

// File: tb/tb_pmem_fetch_arbiter.sv
// tb_pmem_fetch_arbiter: directed checks of the fetch arbiter with one and two cache channels
module tb_pmem_fetch_arbiter;
  logic clk;
  logic rst_n;

  logic [1:0]  v1;
  logic [15:0] a1;
  logic [1:0]  r1;
  logic [31:0] dd1;
  logic [0:0]  cv1;
  logic [7:0]  ca1;
  logic [0:0]  crdy1;
  logic [15:0] cdat1;

  logic [1:0]  v2;
  logic [15:0] a2;
  logic [1:0]  r2;
  logic [31:0] dd2;
  logic [1:0]  cv2;
  logic [15:0] ca2;
  logic [1:0]  crdy2;
  logic [31:0] cdat2;

  int tests = 0;
  int fails = 0;

  pmem_fetch_arbiter #(.ADDR_BITS(8), .DATA_BITS(16), .NUM_CONSUMERS(2), .NUM_CHANNELS(1)) d1 (
    .clk                     (clk),
    .rst_n                   (rst_n),
    .consumer_read_valid_i   (v1),
    .consumer_read_address_i (a1),
    .consumer_read_ready_o   (r1),
    .consumer_read_data_o    (dd1),
    .cache_read_valid_o      (cv1),
    .cache_read_address_o    (ca1),
    .cache_read_ready_i      (crdy1),
    .cache_read_data_i       (cdat1)
  );

  pmem_fetch_arbiter #(.ADDR_BITS(8), .DATA_BITS(16), .NUM_CONSUMERS(2), .NUM_CHANNELS(2)) d2 (
    .clk                     (clk),
    .rst_n                   (rst_n),
    .consumer_read_valid_i   (v2),
    .consumer_read_address_i (a2),
    .consumer_read_ready_o   (r2),
    .consumer_read_data_o    (dd2),
    .cache_read_valid_o      (cv2),
    .cache_read_address_o    (ca2),
    .cache_read_ready_i      (crdy2),
    .cache_read_data_i       (cdat2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b1;
    v1 = '0; a1 = '0; crdy1 = '0; cdat1 = '0;
    v2 = '0; a2 = '0; crdy2 = '0; cdat2 = '0;
    #1 rst_n = 1'b0;
    #2;
    chk("rst_r1", 32'(r1), 32'h0);
    chk("rst_cv1", 32'(cv1), 32'h0);
    chk("rst_dd1", dd1, 32'h0);
    chk("rst_cv2", 32'(cv2), 32'h0);
    chk("rst_ca2", 32'(ca2), 32'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // single request, data two cycles later
    v1 = 2'b01; a1 = 16'h0012;
    tick;
    chk("single_cv", 32'(cv1), 32'h1);
    chk("single_ca", 32'(ca1), 32'h12);
    chk("single_r_early", 32'(r1), 32'h0);
    tick;
    crdy1 = 1'b1; cdat1 = 16'hBEEF;
    tick;
    chk("single_r", 32'(r1), 32'h1);
    chk("single_d", dd1, 32'h0000BEEF);
    chk("single_cv_low", 32'(cv1), 32'h0);
    crdy1 = 1'b0;
    tick;
    chk("single_r_hold", 32'(r1), 32'h1);
    v1 = 2'b00;
    tick;
    chk("single_r_drop", 32'(r1), 32'h0);
    chk("single_d_drop", dd1, 32'h0);

    // round-robin order from rr_ptr=0 with one channel
    rst_n = 1'b0;
    #1 rst_n = 1'b1;
    v1 = 2'b11; a1 = 16'h4140;
    for (int n = 0; n < 4; n++) begin
      tick;
      chk("rr_cv", 32'(cv1), 32'h1);
      chk("rr_ca", 32'(ca1), (n % 2) ? 32'h41 : 32'h40);
      crdy1 = 1'b1; cdat1 = 16'(16'h1000 + n);
      tick;
      chk("rr_r", 32'(r1), (n % 2) ? 32'h2 : 32'h1);
      chk("rr_d", (n % 2) ? 32'(dd1[31:16]) : 32'(dd1[15:0]), 32'h1000 + 32'(n));
      crdy1 = 1'b0;
      v1[n % 2] = 1'b0;
      tick;
      chk("rr_r_drop", 32'(r1), 32'h0);
      chk("rr_cv_gap", 32'(cv1), 32'h0);
      if (n < 3) v1[n % 2] = 1'b1;
      else v1 = 2'b00;
    end

    // slow cache release keeps the channel in RELAY
    v1 = 2'b01; a1 = 16'h4155;
    tick;
    chk("slow_cv", 32'(cv1), 32'h1);
    chk("slow_ca", 32'(ca1), 32'h55);
    crdy1 = 1'b1; cdat1 = 16'hCAFE;
    tick;
    chk("slow_r", 32'(r1), 32'h1);
    chk("slow_d", dd1, 32'h0000CAFE);
    v1 = 2'b10;
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("slow_r_hold", 32'(r1), 32'h1);
      chk("slow_cv_block", 32'(cv1), 32'h0);
    end
    crdy1 = 1'b0;
    tick;
    chk("slow_r_drop", 32'(r1), 32'h0);
    chk("slow_cv_exit", 32'(cv1), 32'h0);
    tick;
    chk("slow_next_cv", 32'(cv1), 32'h1);
    chk("slow_next_ca", 32'(ca1), 32'h41);
    crdy1 = 1'b1; cdat1 = 16'h7777;
    tick;
    chk("slow_next_r", 32'(r1), 32'h2);
    chk("slow_next_d", dd1, 32'h77770000);
    crdy1 = 1'b0; v1 = 2'b00;
    tick;
    chk("slow_next_drop", 32'(r1), 32'h0);

    // consumer abandons before data returns
    v1 = 2'b01; a1 = 16'h0066;
    tick;
    chk("abandon_cv", 32'(cv1), 32'h1);
    chk("abandon_ca", 32'(ca1), 32'h66);
    v1 = 2'b00;
    tick;
    chk("abandon_wait_cv", 32'(cv1), 32'h1);
    crdy1 = 1'b1; cdat1 = 16'h1234;
    tick;
    chk("abandon_r", 32'(r1), 32'h1);
    chk("abandon_d", dd1, 32'h00001234);
    crdy1 = 1'b0;
    tick;
    chk("abandon_r_pulse", 32'(r1), 32'h0);
    chk("abandon_d_clr", dd1, 32'h0);
    v1 = 2'b01; a1 = 16'h0067;
    tick;
    chk("abandon_reuse_cv", 32'(cv1), 32'h1);
    chk("abandon_reuse_ca", 32'(ca1), 32'h67);

    // async reset while in REQ, then a fresh fetch
    #2 rst_n = 1'b0;
    #1;
    chk("areset_cv", 32'(cv1), 32'h0);
    chk("areset_ca", 32'(ca1), 32'h0);
    chk("areset_r", 32'(r1), 32'h0);
    v1 = 2'b00;
    #2 rst_n = 1'b1;
    crdy1 = 1'b1; cdat1 = 16'hDEAD;
    tick;
    chk("areset_stale_r", 32'(r1), 32'h0);
    chk("areset_stale_cv", 32'(cv1), 32'h0);
    crdy1 = 1'b0; v1 = 2'b01; a1 = 16'h0068;
    tick;
    chk("areset_new_cv", 32'(cv1), 32'h1);
    chk("areset_new_ca", 32'(ca1), 32'h68);
    crdy1 = 1'b1; cdat1 = 16'h9999;
    tick;
    chk("areset_new_r", 32'(r1), 32'h1);
    chk("areset_new_d", dd1, 32'h00009999);
    crdy1 = 1'b0; v1 = 2'b00;
    tick;
    chk("areset_new_drop", 32'(r1), 32'h0);

    // two channels: one grant per cycle onto the lowest idle channel
    v2 = 2'b11; a2 = 16'hA1A0;
    tick;
    chk("dual_cv_first", 32'(cv2), 32'h1);
    chk("dual_ca0", 32'(ca2[7:0]), 32'hA0);
    tick;
    chk("dual_cv_both", 32'(cv2), 32'h3);
    chk("dual_ca1", 32'(ca2[15:8]), 32'hA1);
    crdy2 = 2'b10; cdat2 = 32'h2222_0000;
    tick;
    chk("dual_r1", 32'(r2), 32'h2);
    chk("dual_d1", dd2, 32'h22220000);
    chk("dual_cv_ch0", 32'(cv2), 32'h1);
    v2 = 2'b01; crdy2 = 2'b01; cdat2 = 32'h0000_3333;
    tick;
    chk("dual_r0", 32'(r2), 32'h1);
    chk("dual_d0", dd2, 32'h00003333);
    crdy2 = 2'b00; v2 = 2'b00;
    tick;
    chk("dual_idle_r", 32'(r2), 32'h0);
    chk("dual_idle_cv", 32'(cv2), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
